// File: rtl/sub_decoder_8_bits.sv
`default_nettype none
// ============================================================================
// Module   : sub_decoder_8_bits
// Brief    : Recovers operand B = {cout,S} - A from a running-sum stream using
//            a bit-serial subtractor with valid/ready handshakes.
//            Optional macro SUB_DEC_ERR_COUNT_EN adds a saturating err_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module sub_decoder_8_bits #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] s_in,
    input  logic         cout_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_b,
    output logic [N-1:0] out_a,
    output logic         err
`ifdef SUB_DEC_ERR_COUNT_EN
    ,
    output logic [7:0]   err_cnt
`endif
);

    localparam int                c_cnt_w = $clog2(N + 1);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(N);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [N-1:0]       r_a;
    logic [N:0]         r_m;
    logic [N:0]         r_sub;
    logic [N-1:0]       r_res;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_bw;

    logic               w_m_bit;
    logic               w_s_bit;
    logic               w_d;
    logic               w_bw_next;
    logic [N:0]         w_res_next;
    logic               w_last;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_HOLD);

    assign w_m_bit    = r_m[r_cnt];
    assign w_s_bit    = r_sub[r_cnt];
    assign w_d        = w_m_bit ^ w_s_bit ^ r_bw;
    assign w_bw_next  = (~w_m_bit & w_s_bit) | (~(w_m_bit ^ w_s_bit) & r_bw);
    assign w_res_next = {w_d, r_res};
    assign w_last     = (r_cnt == c_last);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (clr) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (in_valid)  w_next = S_CALC;
                S_CALC:  if (w_last)    w_next = S_HOLD;
                S_HOLD:  if (out_ready) w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Result bits enter at the top and move down; after N+1 shifts bit 0 is the LSB.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_a   <= '0;
            r_m   <= '0;
            r_sub <= '0;
            r_res <= '0;
            r_cnt <= '0;
            r_bw  <= 1'b0;
            out_b <= '0;
            out_a <= '0;
            err   <= 1'b0;
        end else if (clr) begin
            r_a <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_m   <= {cout_in, s_in};
                        r_sub <= {1'b0, r_a};
                        r_res <= '0;
                        r_cnt <= '0;
                        r_bw  <= 1'b0;
                    end
                end
                S_CALC: begin
                    r_res <= w_res_next[N:1];
                    r_bw  <= w_bw_next;
                    if (w_last) begin
                        out_b <= w_res_next[N-1:0];
                        out_a <= r_sub[N-1:0];
                        // Top bit set: above 2^N-1; final borrow: negative.
                        err   <= w_res_next[N] | w_bw_next;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (out_ready && !err) begin
                        r_a <= out_b;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SUB_DEC_ERR_COUNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_cnt <= 8'd0;
        end else if (clr) begin
            err_cnt <= 8'd0;
        end else if ((r_state == S_HOLD) && out_ready && err && (err_cnt != 8'hFF)) begin
            err_cnt <= err_cnt + 8'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sub_decoder_8_bits.sv
`default_nettype none
// ============================================================================
// Module   : tb_sub_decoder_8_bits
// Brief    : Randomised and directed bench for sub_decoder_8_bits against an
//            arithmetic reference model of B = {cout,S} - A.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sub_decoder_8_bits;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       clr = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] s_in = 8'd0;
    logic       cout_in = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_b;
    logic [7:0] out_a;
    logic       err;
`ifdef SUB_DEC_ERR_COUNT_EN
    logic [7:0] err_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int m_a = 0;
    int m_errcnt = 0;

    sub_decoder_8_bits #(.N(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .s_in      (s_in),
        .cout_in   (cout_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_b     (out_b),
        .out_a     (out_a),
        .err       (err)
`ifdef SUB_DEC_ERR_COUNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Reference: plain integer difference; returns {err, b}.
    function automatic logic [8:0] model(input logic [7:0] s, input logic c, input int a);
        int d;
        logic e;
        d = int'({c, s}) - a;
        e = (d < 0) || (d > 255);
        return {e, 8'(d & 255)};
    endfunction

    function automatic void model_commit(input logic [8:0] r);
        if (!r[8]) m_a = int'(r[7:0]);
        else if (m_errcnt < 255) m_errcnt = m_errcnt + 1;
    endfunction

    task automatic start_txn(input logic [7:0] s, input logic c);
        int w;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        in_valid = 1'b1;
        s_in     = s;
        cout_in  = c;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        s_in     = 8'($urandom);
        cout_in  = 1'($urandom);
    endtask

    task automatic wait_hold(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_txn(input logic [7:0] s, input logic c, input int hold,
                           output logic [7:0] b, output logic [7:0] a,
                           output logic e, output int lat);
        start_txn(s, c);
        wait_hold(lat);
        b = out_b;
        a = out_a;
        e = err;
        repeat (hold) @(negedge clk);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic do_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        m_a = 0;
        m_errcnt = 0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || out_b !== 8'h00 || out_a !== 8'h00 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b b=%h a=%h e=%b expected 0 0 0 0",
                     out_valid, out_b, out_a, err);
        end
`ifdef SUB_DEC_ERR_COUNT_EN
        checks++;
        if (err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_err_cnt: got %0d expected 0", err_cnt);
        end
`endif
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b expected 1", in_ready);
        end
        m_a = 0;
        m_errcnt = 0;
    endtask

    typedef struct {
        logic [7:0] s;
        logic       c;
        logic [7:0] b;
        logic [7:0] a;
        logic       e;
    } vec_t;

    task automatic test_directed();
        vec_t v[8];
        logic [7:0] b, a;
        logic e;
        int lat;
        v[0] = '{8'h05, 1'b0, 8'h05, 8'h00, 1'b0};
        v[1] = '{8'h08, 1'b0, 8'h03, 8'h05, 1'b0};
        v[2] = '{8'hF3, 1'b0, 8'hF0, 8'h03, 1'b0};
        v[3] = '{8'h10, 1'b1, 8'h20, 8'hF0, 1'b0};
        v[4] = '{8'h10, 1'b0, 8'hF0, 8'h20, 1'b1};
        v[5] = '{8'h25, 1'b0, 8'h05, 8'h20, 1'b0};
        v[6] = '{8'h05, 1'b0, 8'h00, 8'h05, 1'b0};
        v[7] = '{8'h10, 1'b1, 8'h10, 8'h00, 1'b1};
        for (int i = 0; i < 8; i++) begin
            run_txn(v[i].s, v[i].c, i % 3, b, a, e, lat);
            checks++;
            if (lat !== 9) begin
                errors++;
                $display("FAIL directed_latency[%0d]: got %0d expected 9", i, lat);
            end
            checks++;
            if (b !== v[i].b || a !== v[i].a || e !== v[i].e) begin
                errors++;
                $display("FAIL directed[%0d]: got b=%h a=%h e=%b expected b=%h a=%h e=%b",
                         i, b, a, e, v[i].b, v[i].a, v[i].e);
            end
            model_commit({v[i].e, v[i].b});
        end
    endtask

    task automatic test_random();
        logic [7:0] s, b, a;
        logic c, e;
        logic [8:0] r;
        int lat;
        for (int i = 0; i < 40; i++) begin
            s = 8'($urandom);
            c = ($urandom_range(0, 3) == 0);
            r = model(s, c, m_a);
            run_txn(s, c, int'($urandom_range(0, 3)), b, a, e, lat);
            checks++;
            if (lat !== 9 || b !== r[7:0] || a !== 8'(m_a) || e !== r[8]) begin
                errors++;
                $display("FAIL random[%0d] s=%h c=%b: got lat=%0d b=%h a=%h e=%b expected lat=9 b=%h a=%h e=%b",
                         i, s, c, lat, b, a, e, r[7:0], 8'(m_a), r[8]);
            end
            model_commit(r);
        end
    endtask

    task automatic test_back_to_back();
        int t0, t1, lat;
        logic [8:0] r;
        // Upstream holds valid and downstream is always ready: one sum per 11 cycles.
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        s_in      = 8'h77;
        cout_in   = 1'b0;
        wait_hold(lat);
        t0 = $time;
        r = model(8'h77, 1'b0, m_a);
        model_commit(r);
        @(negedge clk);
        wait_hold(lat);
        t1 = $time;
        in_valid  = 1'b0;
        r = model(8'h77, 1'b0, m_a);
        checks++;
        if (out_b !== r[7:0] || err !== r[8]) begin
            errors++;
            $display("FAIL b2b_result: got b=%h e=%b expected b=%h e=%b", out_b, err, r[7:0], r[8]);
        end
        model_commit(r);
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if ((t1 - t0) / 10 !== 11) begin
            errors++;
            $display("FAIL b2b_interval: got %0d cycles expected 11", (t1 - t0) / 10);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] b, a;
        logic e;
        logic [8:0] r;
        int lat;
        r = model(8'hC4, 1'b0, m_a);
        start_txn(8'hC4, 1'b0);
        wait_hold(lat);
        b = out_b;
        a = out_a;
        e = err;
        checks++;
        if (b !== r[7:0] || a !== 8'(m_a) || e !== r[8]) begin
            errors++;
            $display("FAIL bp_result: got b=%h a=%h e=%b expected b=%h a=%h e=%b",
                     b, a, e, r[7:0], 8'(m_a), r[8]);
        end
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            s_in     = 8'($urandom);
            cout_in  = 1'($urandom);
            @(negedge clk);
            checks++;
            if (out_b !== b || out_a !== a || err !== e || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got b=%h a=%h e=%b rdy=%b v=%b expected b=%h a=%h e=%b rdy=0 v=1",
                         i, out_b, out_a, err, in_ready, out_valid, b, a, e);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release: got v=%b rdy=%b expected v=0 rdy=1", out_valid, in_ready);
        end
        model_commit(r);
    endtask

    task automatic test_clr_abort();
        logic [7:0] b, a;
        logic e;
        logic seen;
        int lat;
        run_txn(8'h33, 1'b0, 0, b, a, e, lat);
        model_commit(model(8'h33, 1'b0, m_a));
        start_txn(8'h99, 1'b0);
        repeat (3) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        m_a = 0;
        m_errcnt = 0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL clr_idle: got rdy=%b v=%b expected rdy=1 v=0", in_ready, out_valid);
        end
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL clr_no_valid: got out_valid seen=%b expected 0", seen);
        end
        run_txn(8'h44, 1'b0, 0, b, a, e, lat);
        checks++;
        if (a !== 8'h00 || b !== 8'h44 || e !== 1'b0) begin
            errors++;
            $display("FAIL clr_a_zero: got a=%h b=%h e=%b expected a=00 b=44 e=0", a, b, e);
        end
        model_commit(model(8'h44, 1'b0, 0));
    endtask

    task automatic test_reset_abort();
        logic [7:0] b, a;
        logic e;
        int lat;
        start_txn(8'h50, 1'b0);
        wait_hold(lat);
        reset = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_b !== 8'h00 || out_a !== 8'h00 || err !== 1'b0) begin
            errors++;
            $display("FAIL rst_abort: got v=%b b=%h a=%h e=%b expected 0 0 0 0",
                     out_valid, out_b, out_a, err);
        end
        @(negedge clk);
        reset = 1'b1;
        m_a = 0;
        m_errcnt = 0;
        run_txn(8'h12, 1'b0, 0, b, a, e, lat);
        checks++;
        if (a !== 8'h00 || b !== 8'h12) begin
            errors++;
            $display("FAIL rst_a_zero: got a=%h b=%h expected a=00 b=12", a, b);
        end
        model_commit(model(8'h12, 1'b0, 0));
    endtask

`ifdef SUB_DEC_ERR_COUNT_EN
    task automatic test_err_count();
        logic [7:0] b, a;
        logic e;
        int lat;
        do_clr();
        checks++;
        if (err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL errcnt_clr: got %0d expected 0", err_cnt);
        end
        for (int i = 0; i < 258; i++) begin
            run_txn(8'h10, 1'b1, 0, b, a, e, lat);
            model_commit(model(8'h10, 1'b1, m_a));
            checks++;
            if (err_cnt !== 8'(m_errcnt)) begin
                errors++;
                $display("FAIL errcnt[%0d]: got %0d expected %0d", i, err_cnt, m_errcnt);
            end
        end
        run_txn(8'h01, 1'b0, 0, b, a, e, lat);
        model_commit(model(8'h01, 1'b0, m_a));
        checks++;
        if (err_cnt !== 8'd255) begin
            errors++;
            $display("FAIL errcnt_sat: got %0d expected 255", err_cnt);
        end
        do_clr();
        checks++;
        if (err_cnt !== 8'd0) begin
            errors++;
            $display("FAIL errcnt_clr2: got %0d expected 0", err_cnt);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_clr_abort();
        test_reset_abort();
`ifdef SUB_DEC_ERR_COUNT_EN
        test_err_count();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
